// File: rtl/vliw_pipe_pkg.sv
// Shared register-index types, slot descriptors and FSM states
// for the 2-slot (R/S) VLIW issue-side hazard logic.
package vliw_pipe_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t src_a;
        reg_idx_t src_b;
        reg_idx_t dst;
        logic     wr;
        logic     ld;
    } slot_ctl_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } haz_state_e;

    // True when this slot is a load whose result lands in register idx.
    function automatic logic loads_into(input slot_ctl_t slot, input reg_idx_t idx);
        return slot.wr && slot.ld && (slot.dst == idx) && (idx != '0);
    endfunction

endpackage

// File: rtl/hazard_reg_cnt.sv
// Load-use countdown for one architectural register; busy while the count is nonzero.
module hazard_reg_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    input  logic             flush,
    input  logic             dec,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignment so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/vliw_hazard_scoreboard.sv
// Issue-side load-use hazard unit for the 2-slot VLIW pipeline (stall/bubble generation).
// Optional HAZ_STALL_CNT_EN adds a saturating 32-bit stall_cycles counter port.
module vliw_hazard_scoreboard
    import vliw_pipe_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rm,
    input  logic [REG_W-1:0]    id_rn,
    input  logic [REG_W-1:0]    id_sm,
    input  logic [REG_W-1:0]    id_sn,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [REG_W-1:0]    id_sd,
    input  logic                id_rwr,
    input  logic                id_swr,
    input  logic                id_rld,
    input  logic                id_sld,
    input  logic                flush,
    output logic                stall,
    output logic                bubble,
    output logic                bundle_err,
    output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    slot_ctl_t             r_slot;
    slot_ctl_t             s_slot;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:1]   load_vec;
    logic                  src_hit;
    logic                  issue;
    haz_state_e            state_q;
    haz_state_e            state_d;

    always_comb begin
        r_slot = '{src_a: id_rm, src_b: id_rn, dst: id_rd, wr: id_rwr, ld: id_rld};
        s_slot = '{src_a: id_sm, src_b: id_sn, dst: id_sd, wr: id_swr, ld: id_sld};

        // busy[0] is tied low, so a zero source index can never hit.
        src_hit = id_valid && (busy[r_slot.src_a] || busy[r_slot.src_b] ||
                               busy[s_slot.src_a] || busy[s_slot.src_b]);
        stall   = src_hit && !flush;
        bubble  = stall || flush;
        issue   = id_valid && !stall && !flush;
        state_d = stall ? HOLD : RUN;

        load_vec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            load_vec[i] = issue && (loads_into(r_slot, reg_idx_t'(i)) ||
                                    loads_into(s_slot, reg_idx_t'(i)));
        end

        bundle_err = id_valid &&
            ((r_slot.wr && s_slot.wr && (r_slot.dst == s_slot.dst) && (r_slot.dst != '0)) ||
             (r_slot.wr && (r_slot.dst != '0) &&
              ((r_slot.dst == s_slot.src_a) || (r_slot.dst == s_slot.src_b))));
    end

    assign busy[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        hazard_reg_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_vec[g]),
            .val   (CNT_W'(LOAD_LAT)),
            .flush (flush),
            .dec   (1'b1),
            .busy  (busy[g])
        );
    end

    assign busy_vec = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // No load can issue while stalled, so a single-cycle latency never stalls twice in a row.
    assert property (@(posedge clk) disable iff (!rst_n)
                     ((state_q == HOLD) && (LOAD_LAT == 1)) |-> !stall);

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((state_d == HOLD) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_vliw_hazard_scoreboard.sv
// Bench for vliw_hazard_scoreboard: two instances (LOAD_LAT 1 and 2) on shared stimulus,
// directed scenarios plus random traffic against a remaining-cycles reference model.
module tb_vliw_hazard_scoreboard;
    import vliw_pipe_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic     id_valid, flush;
    reg_idx_t id_rm, id_rn, id_sm, id_sn, id_rd, id_sd;
    logic     id_rwr, id_swr, id_rld, id_sld;

    logic                stall_a, bubble_a, err_a;
    logic                stall_b, bubble_b, err_b;
    logic [NUM_REGS-1:0] busy_a, busy_b;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0]         sc_a, sc_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vliw_hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rm(id_rm), .id_rn(id_rn), .id_sm(id_sm), .id_sn(id_sn),
        .id_rd(id_rd), .id_sd(id_sd), .id_rwr(id_rwr), .id_swr(id_swr),
        .id_rld(id_rld), .id_sld(id_sld), .flush(flush),
        .stall(stall_a), .bubble(bubble_a), .bundle_err(err_a), .busy_vec(busy_a)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cycles(sc_a)
`endif
    );

    vliw_hazard_scoreboard #(.LOAD_LAT(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rm(id_rm), .id_rn(id_rn), .id_sm(id_sm), .id_sn(id_sn),
        .id_rd(id_rd), .id_sd(id_sd), .id_rwr(id_rwr), .id_swr(id_swr),
        .id_rld(id_rld), .id_sld(id_sld), .flush(flush),
        .stall(stall_b), .bubble(bubble_b), .bundle_err(err_b), .busy_vec(busy_b)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cycles(sc_b)
`endif
    );

    // Reference model: cycles until each register's load result is forwardable.
    int rem [2][NUM_REGS];
    int model_stalls [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic bit model_stall(input int k);
        reg_idx_t srcs [4];
        bit hit = 1'b0;
        srcs = '{id_rm, id_rn, id_sm, id_sn};
        foreach (srcs[j]) begin
            if (srcs[j] != 0 && rem[k][srcs[j]] > 0) hit = 1'b1;
        end
        return id_valid && hit && !flush;
    endfunction

    function automatic logic [NUM_REGS-1:0] model_busy(input int k);
        logic [NUM_REGS-1:0] v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[i] = (rem[k][i] > 0);
        return v;
    endfunction

    function automatic bit model_err();
        bit waw = id_rwr && id_swr && (id_rd != 0) && (id_rd == id_sd);
        bit raw = id_rwr && (id_rd != 0) && ((id_rd == id_sm) || (id_rd == id_sn));
        return id_valid && (waw || raw);
    endfunction

    function automatic int next_rem(input int k, input int i);
        bit loads;
        if (flush) return 0;
        loads = (id_rwr && id_rld && id_rd == i) || (id_swr && id_sld && id_sd == i);
        if (i != 0 && id_valid && !model_stall(k) && loads) return lat_of(k);
        return (rem[k][i] > 0) ? rem[k][i] - 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                model_stalls[k] <= 0;
                for (int i = 0; i < NUM_REGS; i++) rem[k][i] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                model_stalls[k] <= model_stalls[k] + (model_stall(k) ? 1 : 0);
                for (int i = 0; i < NUM_REGS; i++) rem[k][i] <= next_rem(k, i);
            end
        end
    end

    task automatic idle();
        id_valid = 1'b0; flush = 1'b0;
        id_rm = '0; id_rn = '0; id_sm = '0; id_sn = '0; id_rd = '0; id_sd = '0;
        id_rwr = 1'b0; id_swr = 1'b0; id_rld = 1'b0; id_sld = 1'b0;
    endtask

    task automatic set_bundle(input reg_idx_t rm, input reg_idx_t rn, input reg_idx_t sm,
                              input reg_idx_t sn, input reg_idx_t rd, input reg_idx_t sd,
                              input logic rwr, input logic swr, input logic rld, input logic sld);
        id_valid = 1'b1; flush = 1'b0;
        id_rm = rm; id_rn = rn; id_sm = sm; id_sn = sn; id_rd = rd; id_sd = sd;
        id_rwr = rwr; id_swr = swr; id_rld = rld; id_sld = sld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_bundle(3, 3, 3, 3, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        #3;
        n_checks++; if (stall_a !== 1'b0) $display("FAIL reset_stall_a got %b want 0", stall_a); else n_pass++;
        n_checks++; if (bubble_a !== 1'b0) $display("FAIL reset_bubble_a got %b want 0", bubble_a); else n_pass++;
        n_checks++; if (busy_a !== '0) $display("FAIL reset_busy_a got %b want 0", busy_a); else n_pass++;
        n_checks++; if (err_a !== 1'b1) $display("FAIL reset_err_follows got %b want 1", err_a); else n_pass++;
        step();
        n_checks++; if (busy_b !== '0) $display("FAIL reset_busy_b got %b want 0", busy_b); else n_pass++;
        n_checks++; if (stall_b !== 1'b0) $display("FAIL reset_stall_b got %b want 0", stall_b); else n_pass++;
`ifdef HAZ_STALL_CNT_EN
        n_checks++; if (sc_a !== 32'd0) $display("FAIL reset_sc_a got %0d want 0", sc_a); else n_pass++;
`endif
        rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_load_use();
        idle(); repeat (3) step();
        set_bundle(0, 0, 0, 0, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b0) $display("FAIL lu_load_issue got %b want 0", stall_a); else n_pass++;
        step();
        set_bundle(3, 0, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b1) $display("FAIL lu_stall got %b want 1", stall_a); else n_pass++;
        n_checks++; if (bubble_a !== 1'b1) $display("FAIL lu_bubble got %b want 1", bubble_a); else n_pass++;
        n_checks++; if (busy_a[3] !== 1'b1) $display("FAIL lu_busy3 got %b want 1", busy_a[3]); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b0) $display("FAIL lu_release got %b want 0", stall_a); else n_pass++;
        n_checks++; if (bubble_a !== 1'b0) $display("FAIL lu_release_bubble got %b want 0", bubble_a); else n_pass++;
        n_checks++; if (stall_b !== 1'b1) $display("FAIL lu_lat2_second got %b want 1", stall_b); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (stall_b !== 1'b0) $display("FAIL lu_lat2_release got %b want 0", stall_b); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_alu_use();
        idle(); repeat (3) step();
        set_bundle(0, 0, 0, 0, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_bundle(0, 0, 5, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if ({stall_a, stall_b} !== 2'b00) $display("FAIL alu_stall got %b want 00", {stall_a, stall_b}); else n_pass++;
        n_checks++; if ({busy_a[5], busy_b[5]} !== 2'b00) $display("FAIL alu_busy5 got %b want 00", {busy_a[5], busy_b[5]}); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_flush();
        idle(); repeat (3) step();
        set_bundle(0, 0, 0, 0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        set_bundle(0, 2, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if ({stall_a, stall_b} !== 2'b00) $display("FAIL flush_stall got %b want 00", {stall_a, stall_b}); else n_pass++;
        n_checks++; if ({bubble_a, bubble_b} !== 2'b11) $display("FAIL flush_bubble got %b want 11", {bubble_a, bubble_b}); else n_pass++;
        step();
        idle();
        @(negedge clk);
        n_checks++; if ({busy_a, busy_b} !== '0) $display("FAIL flush_busy got %b/%b want 0", busy_a, busy_b); else n_pass++;
        step();
    endtask

    task automatic test_reg0_and_err();
        idle(); repeat (3) step();
        set_bundle(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        @(negedge clk);
        n_checks++; if ({busy_a, busy_b} !== '0) $display("FAIL r0_busy got %b/%b want 0", busy_a, busy_b); else n_pass++;
        set_bundle(0, 0, 0, 0, 4, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (err_a !== 1'b1) $display("FAIL err_waw got %b want 1", err_a); else n_pass++;
        set_bundle(0, 0, 6, 0, 6, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++; if (err_b !== 1'b1) $display("FAIL err_raw got %b want 1", err_b); else n_pass++;
        set_bundle(0, 0, 5, 3, 6, 7, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (err_a !== 1'b0) $display("FAIL err_legal got %b want 0", err_a); else n_pass++;
        set_bundle(0, 0, 0, 0, 4, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (err_a !== 1'b0) $display("FAIL err_nowr got %b want 0", err_a); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        int  na   = 0;
        int  nb   = 0;
        bit  done = 1'b0;
        idle(); repeat (3) step();
        set_bundle(0, 0, 0, 0, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        step();
        set_bundle(3, 0, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (stall_a === 1'b1) na++;
            if (stall_b === 1'b1) nb++;
            if (stall_a !== 1'b1 && stall_b !== 1'b1) done = 1'b1;
            step();
        end
        n_checks++; if (!done) $display("FAIL b2b_timeout stalls still high after 8 cycles, want release"); else n_pass++;
        n_checks++; if (na !== 1) $display("FAIL b2b_len_lat1 got %0d want 1", na); else n_pass++;
        n_checks++; if (nb !== 2) $display("FAIL b2b_len_lat2 got %0d want 2", nb); else n_pass++;
        idle();
    endtask

    task automatic test_random(input int n_cycles);
        logic                obs_stall, obs_bubble, obs_err;
        logic [NUM_REGS-1:0] obs_busy;
        for (int c = 0; c < n_cycles; c++) begin
            id_valid = ($urandom_range(7) != 0);
            flush    = ($urandom_range(15) == 0);
            id_rm = reg_idx_t'($urandom_range(7)); id_rn = reg_idx_t'($urandom_range(7));
            id_sm = reg_idx_t'($urandom_range(7)); id_sn = reg_idx_t'($urandom_range(7));
            id_rd = reg_idx_t'($urandom_range(7)); id_sd = reg_idx_t'($urandom_range(7));
            id_rwr = 1'($urandom_range(1)); id_swr = 1'($urandom_range(1));
            id_rld = 1'($urandom_range(1)); id_sld = 1'($urandom_range(1));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                obs_stall  = (k == 0) ? stall_a  : stall_b;
                obs_bubble = (k == 0) ? bubble_a : bubble_b;
                obs_err    = (k == 0) ? err_a    : err_b;
                obs_busy   = (k == 0) ? busy_a   : busy_b;
                n_checks++;
                if (obs_stall !== model_stall(k))
                    $display("FAIL rand_stall[%0d] cyc %0d got %b want %b", k, c, obs_stall, model_stall(k));
                else n_pass++;
                n_checks++;
                if (obs_bubble !== (model_stall(k) || flush))
                    $display("FAIL rand_bubble[%0d] cyc %0d got %b want %b", k, c, obs_bubble, model_stall(k) || flush);
                else n_pass++;
                n_checks++;
                if (obs_err !== model_err())
                    $display("FAIL rand_err[%0d] cyc %0d got %b want %b", k, c, obs_err, model_err());
                else n_pass++;
                n_checks++;
                if (obs_busy !== model_busy(k))
                    $display("FAIL rand_busy[%0d] cyc %0d got %b want %b", k, c, obs_busy, model_busy(k));
                else n_pass++;
`ifdef HAZ_STALL_CNT_EN
                n_checks++;
                if (((k == 0) ? sc_a : sc_b) !== 32'(model_stalls[k]))
                    $display("FAIL rand_sc[%0d] cyc %0d got %0d want %0d", k, c, (k == 0) ? sc_a : sc_b, model_stalls[k]);
                else n_pass++;
`endif
            end
            step();
        end
        idle();
    endtask

    task automatic test_stall_count();
        idle();
        step();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        for (int p = 0; p < 3; p++) begin
            set_bundle(0, 0, 0, 0, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0);
            step();
            set_bundle(3, 0, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            repeat (3) step();
            idle();
            step();
        end
        @(negedge clk);
`ifdef HAZ_STALL_CNT_EN
        n_checks++; if (sc_b !== 32'd6) $display("FAIL sc_lat2_pairs got %0d want 6", sc_b); else n_pass++;
        n_checks++; if (sc_a !== 32'd3) $display("FAIL sc_lat1_pairs got %0d want 3", sc_a); else n_pass++;
`endif
        step();
        // Start a fresh load-use pair and pull reset in its second stall cycle.
        set_bundle(0, 0, 0, 0, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        set_bundle(0, 0, 0, 4, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        n_checks++; if (stall_b !== 1'b1) $display("FAIL midrst_pre_stall got %b want 1", stall_b); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (stall_b !== 1'b0) $display("FAIL midrst_stall got %b want 0", stall_b); else n_pass++;
        n_checks++; if (bubble_b !== 1'b0) $display("FAIL midrst_bubble got %b want 0", bubble_b); else n_pass++;
        n_checks++; if (busy_b !== '0) $display("FAIL midrst_busy got %b want 0", busy_b); else n_pass++;
`ifdef HAZ_STALL_CNT_EN
        n_checks++; if (sc_b !== 32'd0) $display("FAIL midrst_sc got %0d want 0", sc_b); else n_pass++;
`endif
        step();
        rst_n = 1'b1;
        idle();
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_alu_use();
        test_flush();
        test_reg0_and_err();
        test_back_to_back();
        test_random(400);
        test_stall_count();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
